// File: rtl/lbdr_gen.sv
// Packet-aware LBDR routing unit for one router input port.
// Latches the header route until the tail flit is consumed.
module lbdr_gen #(
  parameter int X_W = 2,
  parameter int Y_W = 2,
  parameter int ADDR_W = X_W + Y_W,
  parameter logic [7:0] DEF_RXY = 8'h3C,
  parameter logic [3:0] DEF_CX = 4'hF,
  parameter logic [ADDR_W-1:0] DEF_ADDR = 5,
  parameter logic [2:0] HEADER = 3'b001,
  parameter logic [2:0] PAYLOAD = 3'b010,
  parameter logic [2:0] TAIL = 3'b100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [7:0]        cfg_rxy,
  input  logic [3:0]        cfg_cx,
  input  logic [ADDR_W-1:0] cfg_cur_addr,
  input  logic              empty,
  input  logic [2:0]        flit_id,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic              rd_en,
  output logic              Nport,
  output logic              Eport,
  output logic              Wport,
  output logic              Sport,
  output logic              Lport,
  output logic              route_valid,
  output logic              route_err,
  output logic              proto_err,
  output logic              busy
);

  typedef enum logic {IDLE, ROUTED} state_e;

  state_e state_q, state_d;
  logic [7:0] rxy_q, rxy_d;
  logic [3:0] cx_q, cx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [4:0] ports_q, ports_d;
  logic rv_q, rv_d;
  logic re_q, re_d;
  logic pe_q, pe_d;

  logic [X_W-1:0] x_cur, x_dst;
  logic [Y_W-1:0] y_cur, y_dst;
  logic n1, s1, e1, w1;
  logic rn, re, rw, rs, rl;
  logic [4:0] route;
  logic is_hdr, is_pay, is_tail;

  assign x_cur = addr_q[X_W-1:0];
  assign y_cur = addr_q[ADDR_W-1:X_W];
  assign x_dst = dst_addr[X_W-1:0];
  assign y_dst = dst_addr[ADDR_W-1:X_W];

  assign n1 = y_dst < y_cur;
  assign s1 = y_cur < y_dst;
  assign e1 = x_cur < x_dst;
  assign w1 = x_dst < x_cur;

  // rxy = {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}, cx = {Cs,Cw,Ce,Cn}
  assign rn = ((n1 & ~e1 & ~w1) | (n1 & e1 & rxy_q[0])
             | (n1 & w1 & rxy_q[1])) & cx_q[0];
  assign re = ((e1 & ~n1 & ~s1) | (e1 & n1 & rxy_q[2])
             | (e1 & s1 & rxy_q[3])) & cx_q[1];
  assign rw = ((w1 & ~n1 & ~s1) | (w1 & n1 & rxy_q[4])
             | (w1 & s1 & rxy_q[5])) & cx_q[2];
  assign rs = ((s1 & ~e1 & ~w1) | (s1 & e1 & rxy_q[6])
             | (s1 & w1 & rxy_q[7])) & cx_q[3];
  assign rl = ~n1 & ~e1 & ~w1 & ~s1;
  assign route = {rn, re, rw, rs, rl};

  assign is_hdr  = flit_id == HEADER;
  assign is_pay  = flit_id == PAYLOAD;
  assign is_tail = flit_id == TAIL;

  always_comb begin
    state_d = state_q;
    rxy_d   = rxy_q;
    cx_d    = cx_q;
    addr_d  = addr_q;
    ports_d = ports_q;
    rv_d    = rv_q;
    re_d    = re_q;
    pe_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_we) begin
          rxy_d  = cfg_rxy;
          cx_d   = cfg_cx;
          addr_d = cfg_cur_addr;
        end
        if (!empty) begin
          if (is_hdr) begin
            ports_d = route;
            rv_d    = 1'b1;
            re_d    = route == 5'd0;
            state_d = ROUTED;
          end else begin
            pe_d = 1'b1;
          end
        end
      end
      ROUTED: begin
        if (!empty) begin
          // a header before the tail restarts the packet
          if (is_hdr) begin
            ports_d = route;
            re_d    = route == 5'd0;
            pe_d    = 1'b1;
          end else if (is_tail) begin
            if (rd_en) begin
              ports_d = 5'd0;
              rv_d    = 1'b0;
              re_d    = 1'b0;
              state_d = IDLE;
            end
          end else if (!is_pay) begin
            pe_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rxy_q   <= DEF_RXY;
      cx_q    <= DEF_CX;
      addr_q  <= DEF_ADDR;
      ports_q <= 5'd0;
      rv_q    <= 1'b0;
      re_q    <= 1'b0;
      pe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rxy_q   <= rxy_d;
      cx_q    <= cx_d;
      addr_q  <= addr_d;
      ports_q <= ports_d;
      rv_q    <= rv_d;
      re_q    <= re_d;
      pe_q    <= pe_d;
    end
  end

  assign {Nport, Eport, Wport, Sport, Lport} = ports_q;
  assign route_valid = rv_q;
  assign route_err   = re_q;
  assign proto_err   = pe_q;
  assign busy        = state_q == ROUTED;

endmodule

// File: tb/tb_lbdr_gen.sv
// Scoreboard bench for lbdr_gen: 4x4 default instance and an
// 8x8 instance; a monitor pops expected outputs each cycle.
module tb_lbdr_gen;

  localparam logic [2:0] HDR = 3'b001;
  localparam logic [2:0] PAY = 3'b010;
  localparam logic [2:0] TL  = 3'b100;

  localparam logic [8:0] PN   = 9'b100000000;
  localparam logic [8:0] PE   = 9'b010000000;
  localparam logic [8:0] PW   = 9'b001000000;
  localparam logic [8:0] PL   = 9'b000010000;
  localparam logic [8:0] RV   = 9'b000001000;
  localparam logic [8:0] RE   = 9'b000000100;
  localparam logic [8:0] PERR = 9'b000000010;
  localparam logic [8:0] BSY  = 9'b000000001;

  typedef struct {
    logic [8:0] ea;
    logic [8:0] eb;
    string nm;
  } rec_t;

  rec_t q[$];
  int checks = 0;
  int errors = 0;
  event ev_async;

  logic clk = 1'b0;
  logic rst;

  logic       a_we, a_empty, a_rd;
  logic [7:0] a_rxy;
  logic [3:0] a_cx;
  logic [3:0] a_cur, a_dst;
  logic [2:0] a_fid;
  logic a_n, a_e, a_w, a_s, a_l, a_rv, a_re, a_pe, a_busy;

  logic       b_we, b_empty, b_rd;
  logic [7:0] b_rxy;
  logic [3:0] b_cx;
  logic [5:0] b_cur, b_dst;
  logic [2:0] b_fid;
  logic b_n, b_e, b_w, b_s, b_l, b_rv, b_re, b_pe, b_busy;

  logic [8:0] eb;
  logic [8:0] act_a, act_b;

  always #5 clk = ~clk;

  lbdr_gen u_a (
    .clk(clk), .rst(rst), .cfg_we(a_we), .cfg_rxy(a_rxy),
    .cfg_cx(a_cx), .cfg_cur_addr(a_cur), .empty(a_empty),
    .flit_id(a_fid), .dst_addr(a_dst), .rd_en(a_rd),
    .Nport(a_n), .Eport(a_e), .Wport(a_w), .Sport(a_s),
    .Lport(a_l), .route_valid(a_rv), .route_err(a_re),
    .proto_err(a_pe), .busy(a_busy)
  );

  lbdr_gen #(.X_W(3), .Y_W(3), .DEF_ADDR(6'b001001)) u_b (
    .clk(clk), .rst(rst), .cfg_we(b_we), .cfg_rxy(b_rxy),
    .cfg_cx(b_cx), .cfg_cur_addr(b_cur), .empty(b_empty),
    .flit_id(b_fid), .dst_addr(b_dst), .rd_en(b_rd),
    .Nport(b_n), .Eport(b_e), .Wport(b_w), .Sport(b_s),
    .Lport(b_l), .route_valid(b_rv), .route_err(b_re),
    .proto_err(b_pe), .busy(b_busy)
  );

  assign act_a = {a_n, a_e, a_w, a_s, a_l,
                  a_rv, a_re, a_pe, a_busy};
  assign act_b = {b_n, b_e, b_w, b_s, b_l,
                  b_rv, b_re, b_pe, b_busy};

  initial begin
    forever begin
      @(negedge clk or ev_async);
      if (q.size() > 0) begin
        rec_t r;
        r = q.pop_front();
        checks++;
        if (act_a !== r.ea) begin
          errors++;
          $display("FAIL %s dutA got %b want %b", r.nm, act_a, r.ea);
        end
        checks++;
        if (act_b !== r.eb) begin
          errors++;
          $display("FAIL %s dutB got %b want %b", r.nm, act_b, r.eb);
        end
      end
    end
  end

  task automatic tick(input logic [8:0] ea, input string nm);
    q.push_back('{ea, eb, nm});
    @(negedge clk);
    #1;
  endtask

  task automatic flit(input logic emp, input logic [2:0] fid,
                      input logic [3:0] dst, input logic rd);
    a_empty = emp;
    a_fid   = fid;
    a_dst   = dst;
    a_rd    = rd;
  endtask

  task automatic cfg(input logic we, input logic [3:0] cx,
                     input logic [3:0] cur);
    a_we  = we;
    a_rxy = 8'h3C;
    a_cx  = cx;
    a_cur = cur;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    eb = 9'd0;
    cfg(1'b0, 4'hF, 4'd5);
    flit(1'b1, 3'b000, 4'd0, 1'b0);
    b_we = 1'b0; b_rxy = 8'h3C; b_cx = 4'hF; b_cur = 6'd0;
    b_empty = 1'b1; b_fid = 3'b000; b_dst = 6'd0; b_rd = 1'b0;
    @(negedge clk);
    #1;
    tick(9'd0, "reset");
    rst = 1'b1;

    flit(1'b0, HDR, 4'd5, 1'b0);
    b_empty = 1'b0; b_fid = HDR; b_dst = 6'b000110;
    eb = PE | RV | BSY;
    tick(PL | RV | BSY, "hdr_local");
    flit(1'b0, TL, 4'd5, 1'b1);
    b_fid = TL; b_rd = 1'b1; eb = 9'd0;
    tick(9'd0, "tail_local");
    b_empty = 1'b1; b_rd = 1'b0;

    flit(1'b0, HDR, 4'd0, 1'b0);
    tick(PW | RV | BSY, "hdr_west");
    flit(1'b0, PAY, 4'd0, 1'b1);
    tick(PW | RV | BSY, "payload_hold");
    flit(1'b1, TL, 4'd0, 1'b1);
    tick(PW | RV | BSY, "empty_hold");
    flit(1'b0, TL, 4'd0, 1'b1);
    tick(9'd0, "tail_clear");
    flit(1'b1, 3'b000, 4'd0, 1'b0);
    tick(9'd0, "idle");

    cfg(1'b1, 4'b1101, 4'd5);
    tick(9'd0, "cfg_no_east");
    cfg(1'b0, 4'b1101, 4'd5);
    flit(1'b0, HDR, 4'd7, 1'b0);
    tick(RV | RE | BSY, "hdr_unroutable");
    flit(1'b0, TL, 4'd7, 1'b1);
    tick(9'd0, "err_clear");
    flit(1'b1, 3'b000, 4'd0, 1'b0);
    cfg(1'b1, 4'hF, 4'd5);
    tick(9'd0, "cfg_restore");
    cfg(1'b0, 4'hF, 4'd5);

    flit(1'b0, TL, 4'd5, 1'b1);
    tick(PERR, "tail_in_idle");
    flit(1'b0, HDR, 4'd5, 1'b0);
    tick(PL | RV | BSY, "hdr_after_err");
    flit(1'b0, HDR, 4'd7, 1'b0);
    tick(PE | RV | BSY | PERR, "hdr_in_routed");
    flit(1'b0, PAY, 4'd7, 1'b1);
    cfg(1'b1, 4'h0, 4'd0);
    tick(PE | RV | BSY, "cfg_while_busy");
    cfg(1'b0, 4'hF, 4'd5);
    flit(1'b0, TL, 4'd7, 1'b1);
    tick(9'd0, "tail_after_cfg");
    flit(1'b0, HDR, 4'd7, 1'b0);
    tick(PE | RV | BSY, "cfg_unchanged");
    flit(1'b0, 3'b011, 4'd7, 1'b1);
    tick(PE | RV | BSY | PERR, "bad_flit_id");
    flit(1'b0, TL, 4'd7, 1'b0);
    tick(PE | RV | BSY, "tail_no_rd");
    flit(1'b0, TL, 4'd7, 1'b1);
    tick(9'd0, "tail_rd");

    flit(1'b1, 3'b000, 4'd0, 1'b0);
    cfg(1'b1, 4'hF, 4'd0);
    tick(9'd0, "cfg_cur0");
    cfg(1'b0, 4'hF, 4'd5);
    flit(1'b0, HDR, 4'd5, 1'b0);
    tick(PE | RV | BSY, "hdr_from_origin");
    flit(1'b0, PAY, 4'd5, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    q.push_back('{9'd0, 9'd0, "async_reset"});
    -> ev_async;
    @(negedge clk);
    #1;
    rst = 1'b1;
    flit(1'b0, HDR, 4'd5, 1'b0);
    tick(PL | RV | BSY, "cfg_defaults");
    flit(1'b0, TL, 4'd5, 1'b1);
    tick(9'd0, "final_tail");
    flit(1'b1, 3'b000, 4'd0, 1'b0);

    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lbdr_gen.md
Name: lbdr_gen

Overview:
Parametrised, packet-aware LBDR routing unit for one router input port in a 2D mesh of any size. The router allocator samples the header flit at the head of the input FIFO and computes the minimal LBDR output port. The port stays latched until the tail flit is consumed. Unlike the fixed 4x4 unit, routing/connectivity/address configuration is reloadable at runtime, and the block flags protocol and unroutable-destination errors.

Parameters:
X_W, 2, width of X coordinate (mesh columns = 2**X_W)
Y_W, 2, width of Y coordinate (mesh rows = 2**Y_W)
ADDR_W, X_W+Y_W, node address width; address = {y, x}
DEF_RXY, 8'h3C, reset routing bits
DEF_CX, 4'hF, reset connectivity bits
DEF_ADDR, 5, reset node address
HEADER, 3'b001, flit_id header code
PAYLOAD, 3'b010, flit_id payload code
TAIL, 3'b100, flit_id tail code

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
cfg_we  in  1  config write strobe
cfg_rxy  in  8  routing bits {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}
cfg_cx  in  4  connectivity bits {Cs,Cw,Ce,Cn}
cfg_cur_addr  in  ADDR_W  this node's address
empty  in  1  input FIFO empty
flit_id  in  3  id of flit at FIFO head
dst_addr  in  ADDR_W  destination of flit at FIFO head
rd_en  in  1  FIFO head flit consumed this cycle
Nport, Eport, Wport, Sport, Lport  out  1 each  latched route request
route_valid  out  1  a route is held for the current packet
route_err  out  1  current packet unroutable (all ports 0)
proto_err  out  1  one-cycle pulse on flit-sequence violation
busy  out  1  state != IDLE; config writes blocked

Behaviour:
- rst low (asynchronous): Rxy=DEF_RXY, Cx=DEF_CX, cur_addr=DEF_ADDR. All ports, route_valid, route_err and proto_err = 0. State = IDLE.
- FSM has two states: IDLE and ROUTED. busy = (state==ROUTED).
- Config: cfg_we in IDLE loads Rxy/Cx/cur_addr at the clock edge. The new values are used from the next cycle. cfg_we in ROUTED is ignored; it causes no error.
- Comparators (unsigned, full width): N1 = y_dst<y_cur; S1 = y_cur<y_dst; E1 = x_cur<x_dst; W1 = x_dst<x_cur.
- Route equations:
  - N = ((N1&~E1&~W1)|(N1&E1&Rne)|(N1&W1&Rnw))&Cn
  - E = ((E1&~N1&~S1)|(E1&N1&Ren)|(E1&S1&Res))&Ce
  - W = ((W1&~N1&~S1)|(W1&N1&Rwn)|(W1&S1&Rws))&Cw
  - S = ((S1&~E1&~W1)|(S1&E1&Rse)|(S1&W1&Rsw))&Cs
  - L = ~N1&~E1&~W1&~S1 (not gated by Cx)
- IDLE, !empty, flit_id==HEADER:
  - Next edge: ports <= route, route_valid=1, state = ROUTED.
  - route_err <= (route==0).
  - Latency is 1 cycle from header visible to ports valid. The header need not be consumed (rd_en) in that cycle.
- ROUTED:
  - Ports are held regardless of empty, flit_id and config inputs.
  - rd_en & !empty & flit_id==TAIL: next edge clears ports, route_valid and route_err; state = IDLE. A header visible in the following cycle routes normally (back-to-back packets, one idle cycle minimum between tail and next route).
- Protocol errors, each a one-cycle proto_err pulse:
  - IDLE with !empty and flit_id PAYLOAD or TAIL: the flit is ignored and state is unchanged.
  - ROUTED with !empty and flit_id==HEADER while the tail has not been seen: the route is recomputed from the new header, state stays ROUTED, and route_err is updated.
  - Any flit_id not in {HEADER, PAYLOAD, TAIL} while !empty.
- empty=1: no state change; rd_en is ignored.
- Packets contain at least 2 flits (header and tail are distinct).
- Reset asserted mid-packet: everything is immediately cleared to reset values, including config.

Test Plan:
- Defaults, X_W=Y_W=2, cur=5; header dst=5 -> cycle+1: Lport=1, others 0, route_valid=1, busy=1.
- Header dst=0 (x0,y0), Rxy=8'h3C -> Wport=1 (Rwn=1), Nport=0 (Rnw=0). Payload then tail with rd_en -> ports held through payload, all 0 and IDLE one cycle after tail.
- cfg_we with cx=4'b1101 (Ce=0), then header dst=7 -> all ports 0, route_err=1. Tail consumed -> route_err=0.
- X_W=Y_W=3, cur=6'b001001; header dst=6'b000110 (x6,y0) -> Eport=1 (Ren=1, Rne=0).
- Protocol: tail in IDLE -> proto_err pulse, no route. Second header in ROUTED with dst=7 -> proto_err pulse, Eport=1. cfg_we while busy -> config unchanged.
- rst low mid-packet (asynchronous, between edges) -> outputs 0 immediately, state IDLE, config back to defaults.
